// File: rtl/powerup_pool.sv
// powerup_pool: multi-slot mushroom/flower manager with a time-multiplexed barrier probe.
// Define POWERUP_PERSIST_EN to keep off-level items frozen instead of freeing them on a room change.
module powerup_pool #(
  parameter int NUM_SLOTS   = 4,
  parameter int HALF        = 9,
  parameter int TILE        = 20,
  parameter int MAX_FALL    = 4,
  parameter int GRAV_PERIOD = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [2:0] level_num,
  input  logic       spawn_valid,
  output logic       spawn_ready,
  input  logic [9:0] spawn_x,
  input  logic [9:0] spawn_y,
  input  logic [2:0] spawn_level,
  input  logic [1:0] spawn_kind,
  output logic [9:0] bar_x,
  output logic [9:0] bar_y,
  output logic [2:0] bar_level,
  input  logic       bar_hit,
  input  logic [9:0] mario_x,
  input  logic [9:0] mario_y,
  input  logic [9:0] mario_Size_Y,
  input  logic [1:0] mario_health,
  input  logic [9:0] luigi_x,
  input  logic [9:0] luigi_y,
  input  logic [9:0] luigi_Size_Y,
  input  logic [1:0] luigi_health,
  output logic       pickup_valid,
  output logic       pickup_player,
  output logic [1:0] pickup_kind,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       is_upgrade,
  output logic [1:0] upgrade_kind,
  output logic [8:0] upgrade_address,
  output logic       frame_overrun
);

  localparam int GW = (GRAV_PERIOD > 1) ? $clog2(GRAV_PERIOD) : 1;
  localparam logic [9:0] H10 = 10'(HALF);
  localparam logic [9:0] SPAN = 10'(2 * HALF);

  typedef enum logic [2:0] {S_IDLE, S_P0, S_P1, S_P2, S_P3, S_P4, S_UPD, S_DONE} seq_t;

  seq_t state, state_n;
  logic [2:0] cur;
  logic [2:0] frame_sync;
  logic tick_r, pending, start, level_clear;
  logic [GW-1:0] frame_cnt;

  logic              active [8];
  logic [9:0]        sx     [8];
  logic [9:0]        sy     [8];
  logic signed [1:0] svx    [8];
  logic [2:0]        svy    [8];
  logic [2:0]        slvl   [8];
  logic [1:0]        skind  [8];
  logic [4:0]        shit   [8];

  logic [9:0] cx, cy;
  logic signed [1:0] cvx;
  logic [2:0] cvy, clvl;
  logic skip, last;

  logic free_found;
  logic [2:0] free_idx;

  logic [10:0] x_step;
  logic hflip, floor_hit, grav, despawn, m_ov, l_ov, pick;
  logic [9:0] new_x, new_y, fall_y, snap_base, snap_y;
  logic [2:0] new_vy, vy_inc;
  logic [3:0] vy_sum;
  logic [9:0] dpx, dpy;

  // Player box test against an item centre; signed 12-bit keeps the vertical edges from wrapping.
  function automatic logic overlap(input logic [9:0] px, input logic [9:0] py,
                                   input logic [9:0] psz, input logic [1:0] hp,
                                   input logic [9:0] ix, input logic [9:0] iy);
    logic [9:0] dx;
    logic signed [11:0] top, bot, itop, ibot;
    dx   = (px >= ix) ? px - ix : ix - px;
    top  = $signed({2'b00, py}) - $signed({2'b00, psz});
    bot  = $signed({2'b00, py}) + $signed({2'b00, psz});
    itop = $signed({2'b00, iy}) - $signed({2'b00, H10});
    ibot = $signed({2'b00, iy}) + $signed({2'b00, H10});
    return (dx < 10'(10 + HALF)) && (top <= ibot) && (bot >= itop) && (hp != 2'b00);
  endfunction

`ifdef POWERUP_PERSIST_EN
  assign level_clear = 1'b0;
`else
  logic [2:0] level_q;
  always_ff @(posedge Clk) begin
    level_q <= level_num;
  end
  assign level_clear = (level_num != level_q);
`endif

  assign cx    = sx[cur];
  assign cy    = sy[cur];
  assign cvx   = svx[cur];
  assign cvy   = svy[cur];
  assign clvl  = slvl[cur];
  assign skip  = !active[cur] || (slvl[cur] != level_num);
  assign last  = (cur == 3'(NUM_SLOTS - 1));
  assign start = tick_r | pending;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        free_found = 1'b1;
        free_idx   = 3'(i);
      end
    end
  end

  assign spawn_ready = !Reset && (state == S_IDLE) && free_found && !start && !level_clear;

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Sequencer next state and the probe point each phase presents to the barrier map.
  always_comb begin
    state_n   = state;
    bar_x     = '0;
    bar_y     = '0;
    bar_level = '0;
    case (state)
      S_IDLE: if (start) state_n = S_P0;
      S_P0: begin
        if (skip) begin
          state_n = last ? S_DONE : S_P0;
        end else begin
          state_n   = S_P1;
          bar_x     = cx - 10'd7;
          bar_y     = cy + H10 + 10'd1;
          bar_level = clvl;
        end
      end
      S_P1: begin
        state_n   = S_P2;
        bar_x     = cx;
        bar_y     = cy + H10 + 10'd1;
        bar_level = clvl;
      end
      S_P2: begin
        state_n   = S_P3;
        bar_x     = cx + 10'd7;
        bar_y     = cy + H10 + 10'd1;
        bar_level = clvl;
      end
      S_P3: begin
        state_n   = S_P4;
        bar_x     = cx;
        bar_y     = cy + {7'b0, cvy} + H10;
        bar_level = clvl;
      end
      S_P4: begin
        state_n   = S_UPD;
        bar_x     = cvx[1] ? cx - (H10 + 10'd1) : cx + (H10 + 10'd1);
        bar_y     = cy;
        bar_level = clvl;
      end
      S_UPD:   state_n = last ? S_DONE : S_P0;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Motion, floor snap, despawn and pickup for the slot under update.
  always_comb begin
    x_step    = {1'b0, cx} + (cvx[1] ? 11'h7FF : 11'h001);
    hflip     = shit[cur][4] || (x_step < 11'(HALF)) || (x_step > 11'(639 - HALF));
    new_x     = hflip ? cx : x_step[9:0];
    floor_hit = |shit[cur][2:0];
    grav      = (frame_cnt == '0);
    vy_sum    = {1'b0, cvy} + 4'd2;
    vy_inc    = (vy_sum > 4'(MAX_FALL)) ? 3'(MAX_FALL) : vy_sum[2:0];
    fall_y    = cy + {7'b0, cvy};
    snap_base = fall_y + H10;
    snap_y    = snap_base - (snap_base % 10'(TILE)) - H10 - 10'd1;
    if (floor_hit) begin
      new_y  = cy;
      new_vy = 3'd0;
    end else if (shit[cur][3]) begin
      new_y  = snap_y;
      new_vy = 3'd0;
    end else begin
      new_y  = fall_y;
      new_vy = grav ? vy_inc : cvy;
    end
    despawn = (new_y > 10'd479);
    m_ov    = overlap(mario_x, mario_y, mario_Size_Y, mario_health, cx, cy);
    l_ov    = overlap(luigi_x, luigi_y, luigi_Size_Y, luigi_health, cx, cy);
    pick    = active[cur] && (m_ov || l_ov);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cur           <= '0;
      frame_sync    <= '0;
      tick_r        <= 1'b0;
      pending       <= 1'b0;
      frame_overrun <= 1'b0;
      frame_cnt     <= '0;
      pickup_valid  <= 1'b0;
      pickup_player <= 1'b0;
      pickup_kind   <= '0;
      for (int i = 0; i < 8; i++) begin
        active[i] <= 1'b0;
        sx[i]     <= '0;
        sy[i]     <= '0;
        svx[i]    <= '0;
        svy[i]    <= '0;
        slvl[i]   <= '0;
        skind[i]  <= '0;
        shit[i]   <= '0;
      end
    end else begin
      frame_sync   <= {frame_sync[1:0], frame_clk};
      tick_r       <= frame_sync[1] & ~frame_sync[2];
      pickup_valid <= 1'b0;

      // A tick arriving while busy is parked once; a second one is lost and flagged.
      if (state == S_IDLE) begin
        pending <= tick_r & pending;
      end else if (tick_r) begin
        if (pending) frame_overrun <= 1'b1;
        else         pending       <= 1'b1;
      end

      if (state == S_IDLE) cur <= '0;
      else if ((state == S_P0 && skip) || state == S_UPD) cur <= cur + 3'd1;

      if (state == S_DONE) begin
        frame_cnt <= (frame_cnt == GW'(GRAV_PERIOD - 1)) ? '0 : frame_cnt + 1'b1;
      end

      case (state)
        S_P0: if (!skip) shit[cur][0] <= bar_hit;
        S_P1: shit[cur][1] <= bar_hit;
        S_P2: shit[cur][2] <= bar_hit;
        S_P3: shit[cur][3] <= bar_hit;
        S_P4: shit[cur][4] <= bar_hit;
        S_UPD: begin
          sx[cur]  <= new_x;
          sy[cur]  <= new_y;
          svx[cur] <= hflip ? -cvx : cvx;
          svy[cur] <= new_vy;
          if (pick) begin
            active[cur]   <= 1'b0;
            pickup_valid  <= 1'b1;
            pickup_player <= !m_ov;
            pickup_kind   <= skind[cur];
          end else if (despawn) begin
            active[cur] <= 1'b0;
          end
        end
        default: ;
      endcase

      if (spawn_valid && spawn_ready) begin
        active[free_idx] <= 1'b1;
        sx[free_idx]     <= spawn_x;
        sy[free_idx]     <= spawn_y;
        svx[free_idx]    <= -2'sd1;
        svy[free_idx]    <= 3'd0;
        slvl[free_idx]   <= spawn_level;
        skind[free_idx]  <= spawn_kind;
      end

      if (level_clear) begin
        for (int i = 0; i < 8; i++) active[i] <= 1'b0;
      end
    end
  end

  // Sprite lookup; scanning high to low lets the lowest-index slot win.
  always_comb begin
    is_upgrade      = 1'b0;
    upgrade_kind    = '0;
    upgrade_address = '0;
    dpx             = '0;
    dpy             = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      dpx = DrawX - sx[i] + H10;
      dpy = DrawY - sy[i] + H10;
      if (active[i] && (slvl[i] == level_num) && (dpx <= SPAN) && (dpy <= SPAN)) begin
        is_upgrade      = 1'b1;
        upgrade_kind    = skind[i];
        upgrade_address = 9'(dpy * 10'(2 * HALF + 1) + dpx);
      end
    end
  end

endmodule

// File: tb/tb_powerup_pool.sv
// Directed bench for powerup_pool: a small barrier-map model, hand-computed positions and pickup log.
// Room-change expectations follow POWERUP_PERSIST_EN when it is defined for the build.
module tb_powerup_pool;

  logic       Clk = 1'b0;
  logic       Reset, frame_clk;
  logic [2:0] level_num;
  logic       spawn_valid, spawn_ready;
  logic [9:0] spawn_x, spawn_y;
  logic [2:0] spawn_level;
  logic [1:0] spawn_kind;
  logic [9:0] bar_x, bar_y;
  logic [2:0] bar_level;
  logic       bar_hit;
  logic [9:0] mario_x, mario_y, mario_Size_Y;
  logic [1:0] mario_health;
  logic [9:0] luigi_x, luigi_y, luigi_Size_Y;
  logic [1:0] luigi_health;
  logic       pickup_valid, pickup_player;
  logic [1:0] pickup_kind;
  logic [9:0] DrawX, DrawY;
  logic       is_upgrade;
  logic [1:0] upgrade_kind;
  logic [8:0] upgrade_address;
  logic       frame_overrun;

  int vectors = 0;
  int miscompares = 0;
  int pk_idx = 0;
  logic [1:0] pk_player_q[$];
  logic [1:0] pk_kind_q[$];

  always #5 Clk = ~Clk;

  powerup_pool dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .level_num(level_num),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_level(spawn_level), .spawn_kind(spawn_kind),
    .bar_x(bar_x), .bar_y(bar_y), .bar_level(bar_level), .bar_hit(bar_hit),
    .mario_x(mario_x), .mario_y(mario_y), .mario_Size_Y(mario_Size_Y), .mario_health(mario_health),
    .luigi_x(luigi_x), .luigi_y(luigi_y), .luigi_Size_Y(luigi_Size_Y), .luigi_health(luigi_health),
    .pickup_valid(pickup_valid), .pickup_player(pickup_player), .pickup_kind(pickup_kind),
    .DrawX(DrawX), .DrawY(DrawY), .is_upgrade(is_upgrade), .upgrade_kind(upgrade_kind),
    .upgrade_address(upgrade_address), .frame_overrun(frame_overrun)
  );

  // Room 0: floor rows 120..139. Room 1: same floor plus a wall tile x 280..299, y 100..119.
  function automatic logic room_hit(input logic [9:0] x, input logic [9:0] y, input logic [2:0] lvl);
    logic floor_row, wall;
    floor_row = (y >= 10'd120) && (y <= 10'd139);
    wall      = (x >= 10'd280) && (x <= 10'd299) && (y >= 10'd100) && (y <= 10'd119);
    if (lvl == 3'd0) return floor_row;
    if (lvl == 3'd1) return floor_row || wall;
    return 1'b0;
  endfunction

  assign bar_hit = room_hit(bar_x, bar_y, bar_level);

  always @(negedge Clk) begin
    if (pickup_valid) begin
      pk_player_q.push_back({1'b0, pickup_player});
      pk_kind_q.push_back(pickup_kind);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue n frame strobes, each followed by enough cycles for a full pass to finish.
  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      frame_clk = 1'b1;
      repeat (3) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (40) @(negedge Clk);
    end
  endtask

  task automatic spawn_item(input logic [9:0] x, input logic [9:0] y,
                            input logic [2:0] lvl, input logic [1:0] kind);
    int waited;
    spawn_x = x; spawn_y = y; spawn_level = lvl; spawn_kind = kind;
    spawn_valid = 1'b1;
    waited = 0;
    while (!spawn_ready && waited < 50) begin
      @(negedge Clk);
      waited++;
    end
    checkOutput("spawn_ack", spawn_ready, 1);
    @(negedge Clk);
    spawn_valid = 1'b0;
  endtask

  task automatic check_pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                           input logic up, input logic [1:0] kind, input logic [8:0] addr);
    DrawX = x; DrawY = y;
    #1;
    checkOutput({tag, "_up"}, is_upgrade, up);
    checkOutput({tag, "_kind"}, upgrade_kind, kind);
    checkOutput({tag, "_addr"}, upgrade_address, addr);
  endtask

  task automatic check_pickup(input string tag, input logic [1:0] player, input logic [1:0] kind);
    logic [1:0] p, k;
    p = (pk_idx < pk_player_q.size()) ? pk_player_q[pk_idx] : 2'd3;
    k = (pk_idx < pk_kind_q.size()) ? pk_kind_q[pk_idx] : 2'd3;
    checkOutput({tag, "_player"}, p, player);
    checkOutput({tag, "_kind"}, k, kind);
    pk_idx++;
  endtask

  task automatic players_away();
    mario_x = 10'd0; mario_y = 10'd0; mario_Size_Y = 10'd16; mario_health = 2'd0;
    luigi_x = 10'd0; luigi_y = 10'd0; luigi_Size_Y = 10'd16; luigi_health = 2'd0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (5) @(negedge Clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; level_num = 3'd0;
    spawn_valid = 1'b0; spawn_x = '0; spawn_y = '0; spawn_level = '0; spawn_kind = '0;
    DrawX = '0; DrawY = '0;
    players_away();
    repeat (3) @(negedge Clk);
    checkOutput("rst_spawn_ready", spawn_ready, 0);
    checkOutput("rst_pickup_valid", pickup_valid, 0);
    checkOutput("rst_overrun", frame_overrun, 0);
    checkOutput("rst_bar_x", bar_x, 0);
    checkOutput("rst_bar_y", bar_y, 0);
    checkOutput("rst_bar_level", bar_level, 0);
    Reset = 1'b0;
    repeat (5) @(negedge Clk);
    check_pix("empty", 10'd300, 10'd100, 1'b0, 2'd0, 9'd0);

    // Drop onto the room-0 floor and settle at y = 110 while drifting left.
    spawn_item(10'd300, 10'd100, 3'd0, 2'd2);
    check_pix("spawn_ctr", 10'd300, 10'd100, 1'b1, 2'd2, 9'd180);
    check_pix("spawn_tl", 10'd291, 10'd91, 1'b1, 2'd2, 9'd0);
    check_pix("spawn_br", 10'd309, 10'd109, 1'b1, 2'd2, 9'd360);
    check_pix("spawn_out", 10'd310, 10'd100, 1'b0, 2'd0, 9'd0);
    applyStimulus(3);
    check_pix("fall3", 10'd297, 10'd104, 1'b1, 2'd2, 9'd180);
    applyStimulus(3);
    check_pix("fall6", 10'd294, 10'd110, 1'b1, 2'd2, 9'd180);
    applyStimulus(14);
    check_pix("settle20", 10'd280, 10'd110, 1'b1, 2'd2, 9'd180);

    // Both players on the item: Mario takes it.
    mario_x = 10'd280; mario_y = 10'd110; mario_health = 2'd2;
    luigi_x = 10'd285; luigi_y = 10'd110; luigi_health = 2'd1;
    applyStimulus(1);
    checkOutput("pk1_count", pk_player_q.size(), 1);
    check_pickup("pk1", 2'd0, 2'd2);
    check_pix("pk1_gone", 10'd280, 10'd110, 1'b0, 2'd0, 9'd0);
    players_away();

    // Wall bounce in room 1: flips at x = 309 and holds there for that frame.
    level_num = 3'd1;
    repeat (3) @(negedge Clk);
    spawn_item(10'd320, 10'd110, 3'd1, 2'd1);
    applyStimulus(11);
    check_pix("wall11", 10'd309, 10'd110, 1'b1, 2'd1, 9'd180);
    applyStimulus(1);
    check_pix("wall12", 10'd309, 10'd110, 1'b1, 2'd1, 9'd180);
    applyStimulus(2);
    check_pix("wall14", 10'd311, 10'd110, 1'b1, 2'd1, 9'd180);
    mario_x = 10'd311; mario_y = 10'd110; mario_health = 2'd3;
    applyStimulus(1);
    check_pickup("pk2", 2'd0, 2'd1);
    players_away();

    // Free fall in empty room 2 from a fresh frame count.
    level_num = 3'd2;
    do_reset();
    spawn_item(10'd500, 10'd400, 3'd2, 2'd3);
    applyStimulus(11);
    check_pix("ff11", 10'd489, 10'd420, 1'b1, 2'd3, 9'd180);
    applyStimulus(1);
    check_pix("ff12", 10'd488, 10'd424, 1'b1, 2'd3, 9'd180);
    applyStimulus(13);
    check_pix("ff25", 10'd475, 10'd476, 1'b1, 2'd3, 9'd180);
    applyStimulus(1);
    check_pix("ff26_gone", 10'd474, 10'd475, 1'b0, 2'd0, 9'd0);
    checkOutput("ff_no_pickup", pk_player_q.size(), 2);

    // Fill every slot, see the extra request stall, then refill the lowest freed slot.
    level_num = 3'd0;
    do_reset();
    spawn_item(10'd100, 10'd110, 3'd0, 2'd0);
    spawn_item(10'd200, 10'd110, 3'd0, 2'd1);
    spawn_item(10'd300, 10'd110, 3'd0, 2'd2);
    spawn_item(10'd400, 10'd110, 3'd0, 2'd3);
    spawn_x = 10'd500; spawn_y = 10'd110; spawn_level = 3'd0; spawn_kind = 2'd0;
    spawn_valid = 1'b1;
    repeat (10) @(negedge Clk);
    checkOutput("full_ready", spawn_ready, 0);
    spawn_valid = 1'b0;
    mario_x = 10'd100; mario_y = 10'd110; mario_health = 2'd2;
    luigi_x = 10'd300; luigi_y = 10'd110; luigi_health = 2'd1;
    applyStimulus(1);
    players_away();
    checkOutput("pk3_count", pk_player_q.size(), 4);
    check_pickup("pk3a", 2'd0, 2'd0);
    check_pickup("pk3b", 2'd1, 2'd2);
    checkOutput("refill_ready", spawn_ready, 1);
    spawn_item(10'd199, 10'd110, 3'd0, 2'd3);
    check_pix("refill_low", 10'd199, 10'd110, 1'b1, 2'd3, 9'd180);

    // Three strobes inside one pass: one parked, one dropped.
    checkOutput("ovr_before", frame_overrun, 0);
    for (int k = 0; k < 3; k++) begin
      frame_clk = 1'b1;
      repeat (2) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (2) @(negedge Clk);
    end
    repeat (60) @(negedge Clk);
    checkOutput("ovr_after", frame_overrun, 1);
    check_pix("ovr_two_pass", 10'd397, 10'd110, 1'b1, 2'd3, 9'd180);

    // Leave the room and come back.
    level_num = 3'd1;
    repeat (3) @(negedge Clk);
    check_pix("away_hidden", 10'd397, 10'd110, 1'b0, 2'd0, 9'd0);
    level_num = 3'd0;
    repeat (3) @(negedge Clk);
`ifdef POWERUP_PERSIST_EN
    check_pix("return", 10'd397, 10'd110, 1'b1, 2'd3, 9'd180);
`else
    check_pix("return", 10'd397, 10'd110, 1'b0, 2'd0, 9'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
